// File: rtl/mips16_pkg.sv
// Shared MIPS16 definitions: bus widths, memory-op opcodes and the data-memory responder state encoding.
package mips16_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 16;

  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/mips16_dmem_array.sv
// DEPTH x DATA_W data storage: one synchronous write port, one asynchronous read port, async clear on rst.
module mips16_dmem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem[IDX_W'(k)] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/mips16_dmem_responder.sv
// Data-memory responder for the MIPS16 LW/SW path: one request at a time, WAIT_CYCLES of latency, then a response.
// Build option: MIPS16_DMEM_WRITE_ACK_EN makes stores return a response beat; otherwise stores are posted.
module mips16_dmem_responder
  import mips16_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  dmem_state_t       state;
  dmem_state_t       state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept_c;
  logic              access_c;
  logic              acc_write_c;
  logic [ADDR_W-1:0] acc_addr_c;
  logic [DATA_W-1:0] acc_wdata_c;
  logic              in_range_c;
  logic              mem_we_c;
  logic              rsp_beat_c;
  logic [DATA_W-1:0] mem_rdata_c;

  mips16_dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (mem_we_c),
    .waddr   (acc_addr_c[IDX_W-1:0]),
    .wdata   (acc_wdata_c),
    .raddr   (acc_addr_c[IDX_W-1:0]),
    .rdata_c (mem_rdata_c)
  );

  // With zero wait cycles the access uses the live request, otherwise the latched copy.
  always_comb begin
    accept_c    = req_valid && req_ready && (state == IDLE);
    acc_write_c = (state == IDLE) ? req_write : wr_q;
    acc_addr_c  = (state == IDLE) ? req_addr  : addr_q;
    acc_wdata_c = (state == IDLE) ? req_wdata : wdata_q;
    access_c    = ((state == WAIT) && (cnt == CNT_W'(1))) || (accept_c && (WAIT_CYCLES == 0));
    in_range_c  = acc_addr_c < ADDR_W'(DEPTH);
    mem_we_c    = access_c && acc_write_c && in_range_c;
`ifdef MIPS16_DMEM_WRITE_ACK_EN
    rsp_beat_c  = 1'b1;
`else
    rsp_beat_c  = !acc_write_c;
`endif
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (WAIT_CYCLES == 0) state_nxt = rsp_beat_c ? RESP : IDLE;
          else                  state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) state_nxt = rsp_beat_c ? RESP : IDLE;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == IDLE);
      if (accept_c) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= CNT_W'(WAIT_CYCLES);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access_c) begin
        rsp_valid <= rsp_beat_c;
        rsp_rdata <= (!acc_write_c && in_range_c) ? mem_rdata_c : '0;
        rsp_err   <= rsp_beat_c && !in_range_c;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips16_dmem_responder.sv
// Self-checking bench: three responders (WAIT_CYCLES 1, 0, 4) against a word-array model with a response scoreboard.
`timescale 1ns/1ps
module tb_mips16_dmem_responder;

  localparam int unsigned NI    = 3;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WC [NI] = '{1, 0, 4};
`ifdef MIPS16_DMEM_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  typedef logic [1:0] idx_t;
  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NI-1:0]   req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [15:0]     req_addr  [NI];
  logic [15:0]     req_wdata [NI];
  logic [15:0]     rsp_rdata [NI];
  logic [15:0]     model [NI][DEPTH];
  exp_t            sb[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mips16_dmem_responder #(
      .DATA_W      (16),
      .ADDR_W      (16),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (WC[g])
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int j = 0; j < NI; j++)
      for (int a = 0; a < DEPTH; a++) model[j][a] = 16'h0;
  endtask

  task automatic do_req(input idx_t i, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, input int bp);
    exp_t e;
    int   n;
    bit   ok;
    bit   in_r;
    bit   beat;
    in_r = addr < 16'(DEPTH);
    beat = !wr || ACK;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i]  = addr;
    req_wdata[i] = data;
    if (bp > 0) rsp_ready[i] = 1'b0;
    ok = 1'b0;
    n  = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        n  = cyc;
      end
    end
    check("accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    if (!ok) return;
    e.err   = beat && !in_r;
    e.rdata = (!wr && in_r) ? model[i][addr[3:0]] : 16'h0;
    e.lat   = 1 + int'(WC[i]);
    if (wr && in_r) model[i][addr[3:0]] = data;
    if (beat) begin
      sb.push_back(e);
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
        @(negedge clk);
        if (rsp_valid[i]) ok = 1'b1;
      end
      e = sb.pop_front();
      check("rsp_seen", 32'(ok), 32'd1);
      if (!ok) return;
      check("latency", 32'(cyc - n), 32'(e.lat));
      check("rdata", 32'(rsp_rdata[i]), 32'(e.rdata));
      check("err", 32'(rsp_err[i]), 32'(e.err));
      check("busy_in_resp", 32'(req_ready[i]), 32'd0);
      for (int k = 0; k < bp; k++) begin
        @(negedge clk);
        check("bp_valid", 32'(rsp_valid[i]), 32'd1);
        check("bp_rdata", 32'(rsp_rdata[i]), 32'(e.rdata));
        check("bp_ready", 32'(req_ready[i]), 32'd0);
      end
      rsp_ready[i] = 1'b1;
      @(negedge clk);
      check("rsp_drop", 32'(rsp_valid[i]), 32'd0);
      check("ready_back", 32'(req_ready[i]), 32'd1);
    end else begin
      for (int k = 1; k <= int'(WC[i]) + 1; k++) begin
        @(negedge clk);
        check("post_no_rsp", 32'(rsp_valid[i]), 32'd0);
        check("post_ready", 32'(req_ready[i]), 32'(k == int'(WC[i]) + 1));
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst       = 1'b0;
    req_valid = '0;
    req_write = '0;
    rsp_ready = '1;
    for (int j = 0; j < NI; j++) begin
      req_addr[j]  = 16'h0;
      req_wdata[j] = 16'h0;
    end
    clear_model();

    // Reset values while rst is held low, then ready one cycle after release
    repeat (3) @(negedge clk);
    for (idx_t j = 0; j < 2'(NI); j++) begin
      check("rst_req_ready", 32'(req_ready[j]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[j]), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata[j]), 32'd0);
      check("rst_rsp_err", 32'(rsp_err[j]), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (idx_t j = 0; j < 2'(NI); j++) check("rel_req_ready", 32'(req_ready[j]), 32'd1);

    do_req(2'd0, 1'b1, 16'd3, 16'h00A5, 0);
    do_req(2'd0, 1'b0, 16'd3, 16'h0, 0);
    do_req(2'd1, 1'b0, 16'd0, 16'h0, 0);
    do_req(2'd2, 1'b0, 16'd0, 16'h0, 0);

    do_req(2'd0, 1'b0, 16'd16, 16'h0, 0);
    do_req(2'd0, 1'b1, 16'hFFFF, 16'h1234, 0);
    for (int a = 0; a < DEPTH; a++) do_req(2'd0, 1'b0, 16'(a), 16'h0, 0);

    do_req(2'd0, 1'b1, 16'd1, 16'h5A5A, 0);
    do_req(2'd0, 1'b0, 16'd1, 16'h0, 5);

    do_req(2'd0, 1'b1, 16'd5, 16'd7, 0);
    do_req(2'd0, 1'b0, 16'd5, 16'h0, 0);

    for (idx_t j = 0; j < 2'(NI); j++) begin
      for (int r = 0; r < 24; r++) begin
        do_req(j, 1'(($urandom_range(0, 1))), 16'($urandom_range(0, 19)), 16'($urandom), 0);
      end
    end

    // Reset asserted mid-WAIT of a store to addr 2 on the 4-wait-cycle responder
    @(posedge clk); #1;
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2]  = 16'd2;
    req_wdata[2] = 16'hBEEF;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[2]) ok = 1'b1;
    end
    check("mid_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_valid", 32'(rsp_valid[2]), 32'd0);
      check("mid_rst_ready", 32'(req_ready[2]), 32'd0);
    end
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    check("mid_rel_ready", 32'(req_ready[2]), 32'd1);
    do_req(2'd2, 1'b0, 16'd2, 16'h0, 0);
    do_req(2'd2, 1'b0, 16'd3, 16'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
